// File: rtl/sensor_alarm.sv
// rtl/sensor_alarm.sv - debounced sensor alarm with acknowledge and alarm counter
//
// Purpose: raises a registered alarm once the raw sensor error flag has been
// sampled high for DEBOUNCE_CYCLES consecutive edges. It snapshots the sensor
// vector on alarm entry and holds the alarm until the operator acknowledges it.
// A fault that is still present at acknowledge parks the FSM in HOLD, so one
// persistent fault produces exactly one alarm.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   error      in   raw combined sensor error flag
//   sensors    in   [3:0] raw sensor vector
//   ack        in   single-cycle operator acknowledge (honoured only in ALARM)
//   alarm      out  registered alarm indication
//   alarm_code out  [3:0] sensors snapshot taken on alarm entry
//   err_count  out  [7:0] saturating count of alarms raised
//   busy       out  high whenever the FSM is not IDLE
//
// Configuration macro: SENSOR_ALARM_COUNT_EN
//   defined   -> err_count is a saturating 8-bit alarm counter
//   undefined -> err_count is tied to 8'h00 and no counter register exists

module sensor_alarm #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       error,
  input  logic [3:0] sensors,
  input  logic       ack,
  output logic       alarm,
  output logic [3:0] alarm_code,
  output logic [7:0] err_count,
  output logic       busy
);

  // dcnt value at which one more high error sample completes the debounce.
  localparam logic [3:0] DCNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ALARM    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [3:0] dcnt, dcnt_nx;
  logic       enter_alarm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dcnt  <= 4'd0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    case (state)
      IDLE: begin
        if (error) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = ALARM;
            dcnt_nx  = 4'd0;
          end else begin
            state_nx = DEBOUNCE;
            dcnt_nx  = 4'd1;
          end
        end else begin
          dcnt_nx = 4'd0;
        end
      end
      DEBOUNCE: begin
        if (!error) begin
          state_nx = IDLE;
          dcnt_nx  = 4'd0;
        end else if (dcnt >= DCNT_LAST) begin
          state_nx = ALARM;
          dcnt_nx  = 4'd0;
        end else begin
          dcnt_nx = dcnt + 4'd1;
        end
      end
      ALARM: begin
        // error is deliberately ignored here except to pick the exit state.
        if (ack) begin
          state_nx = error ? HOLD : IDLE;
          dcnt_nx  = 4'd0;
        end
      end
      HOLD: begin
        if (!error) begin
          state_nx = IDLE;
          dcnt_nx  = 4'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        dcnt_nx  = 4'd0;
      end
    endcase
  end

  assign enter_alarm = (state_nx == ALARM) && (state != ALARM);
  assign busy        = (state != IDLE);

  // alarm tracks the next state so it rises and falls on the same edge as
  // the FSM enters and leaves ALARM.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm      <= 1'b0;
      alarm_code <= 4'b0000;
    end else begin
      alarm <= (state_nx == ALARM);
      if (enter_alarm) begin
        alarm_code <= sensors;
      end
    end
  end

`ifdef SENSOR_ALARM_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (enter_alarm && (err_count != 8'hff)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/sensor_alarm.md
SENSOR_ALARM -- requirements
Module: sensor_alarm

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 3, number of consecutive sampled-high error cycles needed to raise an alarm; legal range 1..15.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: error  input  1  raw combined sensor error flag from the sensor error detector.
REQ-005 Port: sensors  input  4  raw sensor vector, the same bits the detector evaluates.
REQ-006 Port: ack  input  1  single-cycle operator acknowledge of an active alarm.
REQ-007 Port: alarm  output  1  registered alarm indication.
REQ-008 Port: alarm_code  output  4  registered snapshot of sensors taken on alarm entry.
REQ-009 Port: err_count  output  8  registered count of alarms raised.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, ALARM and HOLD, with a 4-bit debounce counter dcnt.
REQ-012 IDLE, error=1 at edge: if DEBOUNCE_CYCLES=1, go to ALARM; otherwise go to DEBOUNCE with dcnt=1.
REQ-013 IDLE, error=0: stay in IDLE with dcnt=0.
REQ-014 DEBOUNCE, error=0 at edge: return to IDLE with dcnt=0, and no alarm is raised.
REQ-015 DEBOUNCE, error=1, dcnt<DEBOUNCE_CYCLES-1: dcnt increments.
REQ-016 DEBOUNCE, error=1, dcnt=DEBOUNCE_CYCLES-1: go to ALARM.
REQ-017 Alarm timing: alarm rises on the edge sampling the DEBOUNCE_CYCLES-th consecutive high error.
REQ-018 ALARM entry, same edge: alarm_code loads sensors as sampled on that edge, and err_count increments.
REQ-019 err_count SHALL saturate at 255.
REQ-020 ALARM holds alarm=1 and alarm_code stable until ack=1 is sampled; error changes in ALARM are ignored.
REQ-021 ALARM, ack=1, error=1: go to HOLD, alarm=0.
REQ-022 ALARM, ack=1, error=0: go to IDLE, alarm=0.
REQ-023 HOLD: alarm stays 0 until error=0 is sampled, then go to IDLE, so one persistent fault yields exactly one alarm.
REQ-024 ack SHALL be ignored in IDLE, DEBOUNCE and HOLD.
REQ-025 alarm_code holds its last value after alarm clears and is overwritten only on the next ALARM entry.
REQ-026 busy SHALL be combinational from state: 1 in DEBOUNCE, ALARM and HOLD; 0 in IDLE.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-028 rst=1 at a rising edge SHALL force state=IDLE, dcnt=0, alarm=0, alarm_code=4'b0000, err_count=0, overriding all other inputs.
REQ-029 rst=1 in any state, including mid-DEBOUNCE or ALARM, SHALL discard progress.
REQ-030 On the first edge with rst=0, the block SHALL behave as from IDLE.

Configuration
REQ-031 Macro SENSOR_ALARM_COUNT_EN defined: err_count register and the increment/saturate logic of REQ-018/019 SHALL be compiled in.
REQ-032 Macro SENSOR_ALARM_COUNT_EN undefined: err_count SHALL be constant 8'h00, with no counter register; all other behaviour is unchanged.

Verification (DEBOUNCE_CYCLES=3, SENSOR_ALARM_COUNT_EN defined)
REQ-033 Clean alarm: error=1 for 3 edges with sensors=4'b0110 -> alarm=1 after the 3rd edge, alarm_code=4'b0110, err_count=1, busy=1.
REQ-034 Glitch reject: error=1 for 2 edges then 0 -> alarm stays 0, state returns to IDLE, busy=0, err_count=0.
REQ-035 Persistent fault: alarm up, ack=1 for 1 cycle with error=1 held -> alarm=0; no re-alarm while error stays 1.
REQ-035 (cont.) Then error=0 for 1 edge, then 3 more high edges -> alarm=1 and err_count=2.
REQ-036 Reset mid-operation: rst=1 during DEBOUNCE (dcnt=2) or ALARM -> next cycle alarm=0, alarm_code=0, err_count=0, busy=0.
REQ-037 Saturation: 260 alarm/ack cycles -> err_count reads 255.
REQ-037 (cont.) Build without SENSOR_ALARM_COUNT_EN -> err_count=0 throughout.
REQ-038 Stray ack: ack=1 in IDLE, and on the 2nd debounce edge -> ignored; alarm still rises on the 3rd high edge.
